// File: rtl/data_ram_arbiter_pkg.sv
// data_ram_arbiter_pkg: shared grant encoding, bus width and burst default
// for the two-master data RAM arbiter.
package data_ram_arbiter_pkg;
    localparam int REG_BUS = 32;
    localparam int ARB_MAX_BURST_DEF = 4;
    typedef enum logic {BUS_M0 = 1'b0, BUS_M1 = 1'b1} grant_e;
    function automatic grant_e other_of(input grant_e g);
        return (g == BUS_M0) ? BUS_M1 : BUS_M0;
    endfunction
endpackage

// File: rtl/data_ram_arbiter_if.sv
// data_ram_arbiter_if: one master's request/ack bus into the data RAM arbiter.
interface data_ram_arbiter_if;
    import data_ram_arbiter_pkg::*;
    logic               req;
    logic               we;
    logic [REG_BUS-1:0] addr;
    logic [3:0]         sel;
    logic [REG_BUS-1:0] wdata;
    logic [REG_BUS-1:0] rdata;
    logic               ack;
    modport master (output req, we, addr, sel, wdata, input rdata, ack);
    modport slave (input req, we, addr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/data_ram_arb_mux.sv
// data_ram_arb_mux: combinational command mux onto the RAM plus ack steering,
// selected by the grant register; i_en low blocks every access.
module data_ram_arb_mux
    import data_ram_arbiter_pkg::*;
(
    input  logic               i_en,
    input  grant_e             i_grant,
    data_ram_arbiter_if.slave  m0,
    data_ram_arbiter_if.slave  m1,
    output logic               o_ram_ce,
    output logic               o_ram_we,
    output logic [REG_BUS-1:0] o_ram_addr,
    output logic [3:0]         o_ram_sel,
    output logic [REG_BUS-1:0] o_ram_wdata,
    input  logic [REG_BUS-1:0] i_ram_rdata
);
    logic w_sel1;
    logic w_acc;
    assign w_sel1      = (i_grant == BUS_M1);
    assign w_acc       = i_en && (w_sel1 ? m1.req : m0.req);
    assign o_ram_ce    = w_acc;
    assign o_ram_we    = w_acc && (w_sel1 ? m1.we : m0.we);
    assign o_ram_addr  = w_sel1 ? m1.addr : m0.addr;
    assign o_ram_sel   = w_sel1 ? m1.sel : m0.sel;
    assign o_ram_wdata = w_sel1 ? m1.wdata : m0.wdata;
    assign m0.ack      = w_acc && !w_sel1;
    assign m1.ack      = w_acc && w_sel1;
    assign m0.rdata    = i_ram_rdata;
    assign m1.rdata    = i_ram_rdata;
endmodule

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: parked-grant, burst-limited arbiter sharing data_ram between two masters.
// Define DATA_RAM_ARB_M0_PRIO_EN to make master 0 non-preemptible and preempt master 1.
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int MAX_BURST = ARB_MAX_BURST_DEF,
    parameter int CNT_W     = 4
)(
    input  logic               clk,
    input  logic               rst,
    data_ram_arbiter_if.slave  m0,
    data_ram_arbiter_if.slave  m1,
    output logic               ram_ce,
    output logic               ram_we,
    output logic [REG_BUS-1:0] ram_addr,
    output logic [3:0]         ram_sel,
    output logic [REG_BUS-1:0] ram_data_o,
    input  logic [REG_BUS-1:0] ram_data_i,
    output logic               grant_o
);
    grant_e           r_grant;
    grant_e           w_grant_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_own_req;
    logic             w_oth_req;
    logic             w_switch;

    data_ram_arb_mux u_mux (
        .i_en        (rst),
        .i_grant     (r_grant),
        .m0          (m0),
        .m1          (m1),
        .o_ram_ce    (ram_ce),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_sel   (ram_sel),
        .o_ram_wdata (ram_data_o),
        .i_ram_rdata (ram_data_i)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grant <= BUS_M0;
            r_cnt   <= '0;
        end else begin
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // An owner request is always acked, so it doubles as the ack count increment.
    always_comb begin
        w_own_req   = (r_grant == BUS_M1) ? m1.req : m0.req;
        w_oth_req   = (r_grant == BUS_M1) ? m0.req : m1.req;
        w_cnt_inc   = r_cnt + CNT_W'(w_own_req);
`ifdef DATA_RAM_ARB_M0_PRIO_EN
        w_switch    = (r_grant == BUS_M1) ? m0.req : (m1.req && !m0.req);
`else
        w_switch    = w_oth_req && (!w_own_req || w_cnt_inc >= CNT_W'(MAX_BURST));
`endif
        w_grant_nxt = w_switch ? other_of(r_grant) : r_grant;
        w_cnt_nxt   = (w_switch || !w_oth_req) ? '0 : w_cnt_inc;
    end

    assign grant_o = r_grant;
endmodule
